// File: rtl/sync_updown_counter.sv
// sync_updown_counter
//   Fully synchronous, parametrised up/down event/timebase counter. Every
//   state bit is clocked by clk, so there is no ripple skew between bits.
//   Features: programmable modulus, runtime direction, count enable,
//   prescaler, parallel load with clamping, wrap or saturate at the
//   boundaries, a one-cycle terminal-count pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE 0 = wrap at the boundaries, 1 = hold at the boundaries
//   PRESCALE enabled clocks per count step (>= 1)
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-low reset
//   en        in   1      count enable (gates prescaler and counter)
//   up        in   1      1 = increment, 0 = decrement
//   load      in   1      synchronous parallel load (highest priority)
//   load_val  in   WIDTH  value to load, clamped to MODULUS-1
//   clr_flag  in   1      synchronous clear of ovf
//   out       out  WIDTH  registered count
//   tc        out  1      registered one-cycle pulse after a boundary event
//   ovf       out  1      sticky: a boundary event has occurred
module sync_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX      = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic             step;
    logic             at_bound;
    logic             bnd_event;
    logic [WIDTH-1:0] cnt_step;
    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        step         = en && !load && (pre == PRE_LAST);
        at_bound     = up ? (out == MAX) : (out == '0);
        bnd_event    = step && at_bound;
        load_clamped = (load_val > MAX) ? MAX : load_val;
        // Wrap is an explicit compare against MAX, so MODULUS = 2**WIDTH
        // never relies on natural overflow of the adder.
        if (at_bound) begin
            if (SATURATE != 0) cnt_step = out;
            else               cnt_step = up ? '0 : MAX;
        end else begin
            cnt_step = up ? out + WIDTH'(1) : out - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
            pre <= '0;
        end else begin
            tc <= bnd_event;
            // A new event beats a coincident clear.
            if (bnd_event)     ovf <= 1'b1;
            else if (clr_flag) ovf <= 1'b0;

            if (load) begin
                out <= load_clamped;
                pre <= '0;
            end else if (en) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
                if (step) out <= cnt_step;
            end
        end
    end

endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter
//   Four counter instances share one stimulus stream:
//     0: MODULUS=10 wrap, 1: MODULUS=10 saturate, 2: MODULUS=10 PRESCALE=3,
//     3: MODULUS=16 (full 4-bit range) wrap.
//   Directed scenarios check fixed expected values; a randomized phase
//   compares every instance against a behavioural model each cycle.
module tb_sync_updown_counter;

    localparam int N = 4;
    localparam int MOD [N] = '{10, 10, 10, 16};
    localparam int SAT [N] = '{0, 1, 0, 0};
    localparam int PRE [N] = '{1, 1, 3, 1};

    logic       clk = 1'b0;
    logic       rst, en, up, load, clr_flag;
    logic [3:0] load_val;
    logic [3:0] q     [N];
    logic       tcw   [N];
    logic       ovfw  [N];

    int checks   = 0;
    int failures = 0;

    int m_cnt [N];
    int m_pre [N];
    bit m_tc  [N];
    bit m_ovf [N];

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .out(q[0]), .tc(tcw[0]), .ovf(ovfw[0]));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .out(q[1]), .tc(tcw[1]), .ovf(ovfw[1]));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_pre (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .out(q[2]), .tc(tcw[2]), .ovf(ovfw[2]));
    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u_full (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .out(q[3]), .tc(tcw[3]), .ovf(ovfw[3]));

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // Behaviour of one clock edge, from the counting rules.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit ev;
            int t;
            ev = 0;
            if (load) begin
                m_cnt[i] = (int'(load_val) > MOD[i] - 1) ? MOD[i] - 1 : int'(load_val);
                m_pre[i] = 0;
            end else if (en) begin
                m_pre[i] = m_pre[i] + 1;
                if (m_pre[i] >= PRE[i]) begin
                    m_pre[i] = 0;
                    t = m_cnt[i] + (up ? 1 : -1);
                    if (t < 0 || t >= MOD[i]) begin
                        ev = 1;
                        if (SAT[i] == 0) m_cnt[i] = (t + MOD[i]) % MOD[i];
                    end else begin
                        m_cnt[i] = t;
                    end
                end
            end
            m_tc[i] = ev;
            if (ev) m_ovf[i] = 1;
            else if (clr_flag) m_ovf[i] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic prep(input logic [3:0] v);
        en = 0; clr_flag = 0; load = 1; load_val = v;
        cycle();
        load = 0; clr_flag = 1;
        cycle();
        clr_flag = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (q[0] !== 4'd0 || tcw[0] !== 1'b0 || ovfw[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: got out=%0d tc=%b ovf=%b, expected 0 0 0", q[0], tcw[0], ovfw[0]);
        end
        rst = 1; model_reset();
        en = 1; up = 1;
        repeat (7) cycle();
        checks++;
        if (q[0] !== 4'd7) begin
            failures++;
            $display("FAIL reset_precount: got out=%0d expected 7", q[0]);
        end
        #2 rst = 0;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (q[i] !== 4'd0 || tcw[i] !== 1'b0 || ovfw[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_async[%0d]: got out=%0d tc=%b ovf=%b, expected 0 0 0", i, q[i], tcw[i], ovfw[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (q[0] !== 4'd0) begin
            failures++;
            $display("FAIL reset_held: got out=%0d expected 0", q[0]);
        end
        rst = 1;
        cycle();
        checks++;
        if (q[0] !== 4'd1) begin
            failures++;
            $display("FAIL reset_resume: got out=%0d expected 1", q[0]);
        end
        en = 0;
    endtask

    task automatic test_up_wrap();
        prep(4'd0);
        en = 1; up = 1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            checks++;
            if (q[0] !== 4'(k % 10) || tcw[0] !== (k == 10) || ovfw[0] !== (k >= 10)) begin
                failures++;
                $display("FAIL up_wrap step %0d: got out=%0d tc=%b ovf=%b, expected %0d %b %b",
                         k, q[0], tcw[0], ovfw[0], k % 10, k == 10, k >= 10);
            end
        end
        en = 0;
    endtask

    task automatic test_down_saturate();
        logic [3:0] exp_q  [4];
        logic       exp_tc [4];
        exp_q  = '{4'd1, 4'd0, 4'd0, 4'd0};
        exp_tc = '{1'b0, 1'b0, 1'b1, 1'b1};
        prep(4'd2);
        en = 1; up = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (q[1] !== exp_q[k] || tcw[1] !== exp_tc[k] || ovfw[1] !== exp_tc[k]) begin
                failures++;
                $display("FAIL down_sat step %0d: got out=%0d tc=%b ovf=%b, expected %0d %b %b",
                         k, q[1], tcw[1], ovfw[1], exp_q[k], exp_tc[k], exp_tc[k]);
            end
        end
        en = 0; clr_flag = 1;
        cycle();
        clr_flag = 0;
        checks++;
        if (ovfw[1] !== 1'b0 || tcw[1] !== 1'b0 || q[1] !== 4'd0) begin
            failures++;
            $display("FAIL down_sat_clear: got out=%0d tc=%b ovf=%b, expected 0 0 0", q[1], tcw[1], ovfw[1]);
        end
    endtask

    task automatic test_load();
        en = 1; up = 1; load = 1; load_val = 4'd13;
        cycle();
        checks++;
        if (q[0] !== 4'd9 || tcw[0] !== 1'b0 || ovfw[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_clamp: got out=%0d tc=%b ovf=%b, expected 9 0 0", q[0], tcw[0], ovfw[0]);
        end
        checks++;
        if (q[3] !== 4'd13) begin
            failures++;
            $display("FAIL load_full: got out=%0d expected 13", q[3]);
        end
        load_val = 4'd4;
        cycle();
        checks++;
        if (q[0] !== 4'd4 || tcw[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_over_step: got out=%0d tc=%b, expected 4 0", q[0], tcw[0]);
        end
        load = 0; en = 0;
    endtask

    task automatic test_prescale();
        prep(4'd0);
        up = 1;
        for (int k = 1; k <= 9; k++) begin
            en = 1;
            cycle();
            checks++;
            if (q[2] !== 4'(k / 3) || tcw[2] !== 1'b0) begin
                failures++;
                $display("FAIL prescale enabled clk %0d: got out=%0d tc=%b, expected %0d 0", k, q[2], tcw[2], k / 3);
            end
            if (k == 4) begin
                en = 0;
                for (int f = 0; f < 5; f++) begin
                    cycle();
                    checks++;
                    if (q[2] !== 4'd1) begin
                        failures++;
                        $display("FAIL prescale_freeze %0d: got out=%0d expected 1", f, q[2]);
                    end
                end
            end
        end
        en = 0;
    endtask

    task automatic test_direction_change();
        prep(4'd9);
        en = 1; up = 1;
        cycle();
        checks++;
        if (q[0] !== 4'd0 || tcw[0] !== 1'b1 || ovfw[0] !== 1'b1) begin
            failures++;
            $display("FAIL dir_up_wrap: got out=%0d tc=%b ovf=%b, expected 0 1 1", q[0], tcw[0], ovfw[0]);
        end
        up = 0; clr_flag = 1;
        cycle();
        checks++;
        if (q[0] !== 4'd9 || tcw[0] !== 1'b1 || ovfw[0] !== 1'b1) begin
            failures++;
            $display("FAIL dir_down_wrap_setwins: got out=%0d tc=%b ovf=%b, expected 9 1 1", q[0], tcw[0], ovfw[0]);
        end
        en = 0; clr_flag = 0;
        cycle();
        checks++;
        if (q[0] !== 4'd9 || tcw[0] !== 1'b0 || ovfw[0] !== 1'b1) begin
            failures++;
            $display("FAIL dir_idle: got out=%0d tc=%b ovf=%b, expected 9 0 1", q[0], tcw[0], ovfw[0]);
        end
        clr_flag = 1;
        cycle();
        clr_flag = 0;
        checks++;
        if (ovfw[0] !== 1'b0) begin
            failures++;
            $display("FAIL dir_clear: got ovf=%b expected 0", ovfw[0]);
        end
    endtask

    task automatic test_full_range();
        prep(4'd15);
        checks++;
        if (q[3] !== 4'd15 || q[0] !== 4'd9) begin
            failures++;
            $display("FAIL full_load: got full=%0d mod10=%0d, expected 15 9", q[3], q[0]);
        end
        en = 1; up = 1;
        cycle();
        checks++;
        if (q[3] !== 4'd0 || tcw[3] !== 1'b1) begin
            failures++;
            $display("FAIL full_up_wrap: got out=%0d tc=%b, expected 0 1", q[3], tcw[3]);
        end
        up = 0;
        cycle();
        checks++;
        if (q[3] !== 4'd15 || tcw[3] !== 1'b1) begin
            failures++;
            $display("FAIL full_down_wrap: got out=%0d tc=%b, expected 15 1", q[3], tcw[3]);
        end
        en = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en       = ($urandom_range(0, 9) < 7);
            up       = $urandom_range(0, 1);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            clr_flag = !load && ($urandom_range(0, 9) == 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (q[i] !== 4'(m_cnt[i]) || tcw[i] !== m_tc[i] || ovfw[i] !== m_ovf[i]) begin
                    failures++;
                    $display("FAIL random cyc %0d inst %0d: got out=%0d tc=%b ovf=%b, expected %0d %b %b",
                             n, i, q[i], tcw[i], ovfw[i], m_cnt[i], m_tc[i], m_ovf[i]);
                end
            end
        end
        en = 0; load = 0; clr_flag = 0;
    endtask

    initial begin
        rst = 0; en = 0; up = 1; load = 0; load_val = '0; clr_flag = 0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_load();
        test_prescale();
        test_direction_change();
        test_full_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
